// File: rtl/burst_word_driver.sv
// burst_word_driver: sends a packet as a contiguous word burst, then collects the response burst with an idle timeout.
module burst_word_driver #(
    parameter int WIDTH     = 6,
    parameter int BURST_LEN = 8,
    parameter int TIMEOUT   = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [WIDTH*BURST_LEN-1:0] load_data,
    output logic [WIDTH-1:0]           tx_data,
    output logic                       tx_valid,
    input  logic [WIDTH-1:0]           rx_data,
    input  logic                       rx_valid,
    output logic [WIDTH*BURST_LEN-1:0] rsp_data,
    output logic                       busy,
    output logic                       done,
    output logic                       timeout,
    output logic [1:0]                 state,
    output logic [3:0]                 word_cnt
);
    localparam int IW = $clog2(TIMEOUT + 1);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_SEND    = 2'd1;
    localparam logic [1:0] S_WAIT    = 2'd2;
    localparam logic [1:0] S_COLLECT = 2'd3;
    localparam logic [3:0] LAST      = 4'(BURST_LEN - 1);
    localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT - 1);

    // r_buf shifts down one word per sent word, so the next word is always just above the bottom
    logic [WIDTH*BURST_LEN-1:0] r_buf;
    logic [IW-1:0]              r_idle;
    logic                       w_stall;

    assign w_stall = r_idle == IDLE_MAX;
    assign busy    = state != S_IDLE;

    // Transaction sequencer: IDLE -> SEND -> WAIT_RSP -> COLLECT -> IDLE, with idle-timeout abort
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            word_cnt <= '0;
            tx_data  <= '0;
            tx_valid <= 1'b0;
            rsp_data <= '0;
            done     <= 1'b0;
            timeout  <= 1'b0;
            r_buf    <= '0;
            r_idle   <= '0;
        end else begin
            done    <= 1'b0;
            timeout <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    r_buf    <= load_data;
                    rsp_data <= '0;
                    word_cnt <= '0;
                    tx_valid <= 1'b1;
                    tx_data  <= load_data[WIDTH-1:0];
                    state    <= S_SEND;
                end
                S_SEND: if (word_cnt == LAST) begin
                    tx_valid <= 1'b0;
                    tx_data  <= '0;
                    word_cnt <= '0;
                    r_idle   <= '0;
                    state    <= S_WAIT;
                end else begin
                    word_cnt <= word_cnt + 1'b1;
                    tx_data  <= r_buf[WIDTH +: WIDTH];
                    r_buf    <= r_buf >> WIDTH;
                end
                S_WAIT, S_COLLECT: if (rx_valid) begin
                    for (int k = 0; k < BURST_LEN; k++)
                        if (word_cnt == 4'(k)) rsp_data[k*WIDTH +: WIDTH] <= rx_data;
                    r_idle <= '0;
                    if (word_cnt == LAST) begin
                        word_cnt <= '0;
                        done     <= 1'b1;
                        state    <= S_IDLE;
                    end else begin
                        word_cnt <= word_cnt + 1'b1;
                        state    <= S_COLLECT;
                    end
                end else if (w_stall) begin
                    r_idle   <= '0;
                    word_cnt <= '0;
                    done     <= 1'b1;
                    timeout  <= 1'b1;
                    state    <= S_IDLE;
                end else begin
                    r_idle <= r_idle + 1'b1;
                end
                default: begin
                    state    <= S_IDLE;
                    word_cnt <= '0;
                    tx_valid <= 1'b0;
                    tx_data  <= '0;
                end
            endcase
        end
    end
endmodule
